// File: rtl/usb_uart_tx_arb.sv
// Round-robin arbiter sharing the usb_uart byte transmit port among N_REQ requesters.
// Owners keep the channel until end-of-message or an idle timeout; bytes are dropped and counted with no host.
module usb_uart_tx_arb #(
   parameter int N_REQ        = 2,
   parameter int LOCK_TIMEOUT = 4800,
   parameter bit DROP_NO_HOST = 1'b1
) (
   input  logic                 clk_48mhz,
   input  logic                 resetq,
   input  logic                 host_presence,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]     req_last,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 uart_wr,
   output logic [7:0]           uart_tx_data,
   input  logic                 uart_busy,
   output logic [15:0]          drop_count
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_OWNED, S_GAP} state_t;

   state_t          r_state, w_state_nxt;
   logic [OW-1:0]   r_owner, w_owner_nxt;
   logic [OW-1:0]   r_last_owner;
   logic [TW-1:0]   r_timer, w_timer_nxt, w_timer_inc;
   logic            r_release, w_release_nxt;
   logic            r_uart_wr;
   logic [7:0]      r_tx_data;
   logic [15:0]     r_drop_count;

   logic [OW-1:0]   w_sel, w_rr_idx;
   logic            w_found;
   logic [N_REQ-1:0] w_owner_oh;
   logic [7:0]      w_owner_byte;
   logic            w_owner_valid, w_owner_last;
   logic            w_can_send, w_xfer, w_timeout;

   // Search starts just past the previous owner, so each requester gets a turn.
   always_comb begin
      w_sel    = r_last_owner;
      w_found  = 1'b0;
      w_rr_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_rr_idx = OW'((int'(r_last_owner) + k) % N_REQ);
         if (!w_found && req_valid[w_rr_idx]) begin
            w_sel   = w_rr_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_owner_oh   = '0;
      w_owner_byte = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_owner == OW'(i)) begin
            w_owner_oh[i] = 1'b1;
            w_owner_byte  = req_data[8*i +: 8];
         end
      end
   end

   assign w_owner_valid = |(req_valid & w_owner_oh);
   assign w_owner_last  = |(req_last & w_owner_oh);
   // Ready is a function of state and sink status only, never of req_valid.
   assign w_can_send    = !uart_busy && (host_presence || DROP_NO_HOST);
   assign w_xfer        = (r_state == S_OWNED) && w_owner_valid && w_can_send;
   assign w_timer_inc   = r_timer + TW'(1);
   assign w_timeout     = (w_timer_inc == TW'(LOCK_TIMEOUT));

   assign grant        = (r_state == S_IDLE) ? '0 : w_owner_oh;
   assign req_ready    = ((r_state == S_OWNED) && w_can_send) ? w_owner_oh : '0;
   assign uart_wr      = r_uart_wr;
   assign uart_tx_data = r_tx_data;
   assign drop_count   = r_drop_count;

   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_timer_nxt   = r_timer;
      w_release_nxt = r_release;
      case (r_state)
         S_IDLE: begin
            w_release_nxt = 1'b0;
            if (w_found) begin
               w_owner_nxt = w_sel;
               w_timer_nxt = '0;
               w_state_nxt = S_OWNED;
            end
         end
         S_OWNED: begin
            if (w_xfer) begin
               w_timer_nxt   = '0;
               w_release_nxt = w_owner_last;
               w_state_nxt   = S_GAP;
            end else if (!w_owner_valid) begin
               if (w_timeout) begin
                  w_timer_nxt = '0;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_timer_nxt = w_timer_inc;
               end
            end
         end
         // One dead cycle lets uart_busy catch up with the write just issued.
         S_GAP: begin
            w_state_nxt = r_release ? S_IDLE : S_OWNED;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_48mhz or negedge resetq) begin
      if (!resetq) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_owner <= OW'(N_REQ - 1);
         r_timer      <= '0;
         r_release    <= 1'b0;
         r_uart_wr    <= 1'b0;
         r_tx_data    <= 8'h00;
         r_drop_count <= 16'h0000;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_timer   <= w_timer_nxt;
         r_release <= w_release_nxt;
         if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE))
            r_last_owner <= r_owner;
         r_uart_wr <= w_xfer && host_presence;
         if (w_xfer && host_presence)
            r_tx_data <= w_owner_byte;
         if (w_xfer && !host_presence && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_usb_uart_tx_arb.sv
// Directed bench for usb_uart_tx_arb: contention, single message, backpressure, timeout, no-host, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_usb_uart_tx_arb;

   logic        clk_48mhz = 1'b0;
   logic        resetq;
   logic        host_presence;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic [1:0]  grant;
   logic        uart_wr;
   logic [7:0]  uart_tx_data;
   logic        uart_busy;
   logic [15:0] drop_count;

   int n_vec = 0;
   int n_err = 0;

   usb_uart_tx_arb #(
      .N_REQ(2),
      .LOCK_TIMEOUT(16),
      .DROP_NO_HOST(1'b1)
   ) dut (
      .clk_48mhz(clk_48mhz),
      .resetq(resetq),
      .host_presence(host_presence),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_last(req_last),
      .req_ready(req_ready),
      .grant(grant),
      .uart_wr(uart_wr),
      .uart_tx_data(uart_tx_data),
      .uart_busy(uart_busy),
      .drop_count(drop_count)
   );

   always #5 clk_48mhz = ~clk_48mhz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      resetq        = 1'b0;
      host_presence = 1'b1;
      req_valid     = 2'b00;
      req_data      = 16'h0000;
      req_last      = 2'b00;
      uart_busy     = 1'b0;

      // Reset state
      @(negedge clk_48mhz);
      @(negedge clk_48mhz);
      chk("rst_grant", grant, 2'b00);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_wr", uart_wr, 1'b0);
      chk("rst_data", uart_tx_data, 8'h00);
      chk("rst_drop", drop_count, 16'h0000);

      // Contention from reset: req0 first, then req1, no interleave
      @(negedge clk_48mhz);
      resetq    = 1'b1;
      req_valid = 2'b11;
      req_data  = 16'hB0A0;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("c1_grant_r0", grant, 2'b01);
      chk("c1_ready_r0", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("c1_wr_a0", uart_wr, 1'b1);
      chk("c1_data_a0", uart_tx_data, 8'hA0);
      chk("c1_gap_ready", req_ready, 2'b00);
      req_data = 16'hB0A1;
      req_last = 2'b01;
      @(negedge clk_48mhz);
      chk("c1_ready_a1", req_ready, 2'b01);
      chk("c1_nowr_a1", uart_wr, 1'b0);
      @(negedge clk_48mhz);
      chk("c1_wr_a1", uart_wr, 1'b1);
      chk("c1_data_a1", uart_tx_data, 8'hA1);
      req_valid = 2'b10;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("c1_idle_grant", grant, 2'b00);
      @(negedge clk_48mhz);
      chk("c1_grant_r1", grant, 2'b10);
      chk("c1_ready_r1", req_ready, 2'b10);
      @(negedge clk_48mhz);
      chk("c1_data_b0", uart_tx_data, 8'hB0);
      chk("c1_wr_b0", uart_wr, 1'b1);
      req_data = 16'hB1A1;
      req_last = 2'b10;
      @(negedge clk_48mhz);
      chk("c1_ready_b1", req_ready, 2'b10);
      @(negedge clk_48mhz);
      chk("c1_data_b1", uart_tx_data, 8'hB1);
      chk("c1_wr_b1", uart_wr, 1'b1);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("c1_end_grant", grant, 2'b00);

      // Single requester: 0x41, 0x42, 0x43 (last)
      req_valid = 2'b01;
      req_data  = 16'h0041;
      @(negedge clk_48mhz);
      chk("s_grant", grant, 2'b01);
      chk("s_ready", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("s_wr_41", uart_wr, 1'b1);
      chk("s_data_41", uart_tx_data, 8'h41);
      req_data = 16'h0042;
      @(negedge clk_48mhz);
      chk("s_nowr", uart_wr, 1'b0);
      @(negedge clk_48mhz);
      chk("s_wr_42", uart_wr, 1'b1);
      chk("s_data_42", uart_tx_data, 8'h42);
      req_data = 16'h0043;
      req_last = 2'b01;
      @(negedge clk_48mhz);
      chk("s_ready_43", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("s_wr_43", uart_wr, 1'b1);
      chk("s_data_43", uart_tx_data, 8'h43);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("s_end_grant", grant, 2'b00);
      chk("s_end_wr", uart_wr, 1'b0);
      chk("s_end_drop", drop_count, 16'h0000);

      // Repeat contention after req0 owned last: req1 goes first
      req_valid = 2'b11;
      req_data  = 16'hD0C0;
      req_last  = 2'b11;
      @(negedge clk_48mhz);
      chk("c2_grant_r1", grant, 2'b10);
      chk("c2_ready_r1", req_ready, 2'b10);
      @(negedge clk_48mhz);
      chk("c2_data_d0", uart_tx_data, 8'hD0);
      req_valid = 2'b01;
      req_last  = 2'b01;
      @(negedge clk_48mhz);
      chk("c2_idle", grant, 2'b00);
      @(negedge clk_48mhz);
      chk("c2_grant_r0", grant, 2'b01);
      @(negedge clk_48mhz);
      chk("c2_data_c0", uart_tx_data, 8'hC0);
      chk("c2_wr_c0", uart_wr, 1'b1);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("c2_end_grant", grant, 2'b00);

      // Backpressure: uart_busy high for 20 cycles mid-message
      req_valid = 2'b01;
      req_data  = 16'h0011;
      @(negedge clk_48mhz);
      chk("bp_ready_11", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("bp_data_11", uart_tx_data, 8'h11);
      req_data  = 16'h0022;
      req_last  = 2'b01;
      uart_busy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_48mhz);
         chk("bp_stall_ready", req_ready, 2'b00);
         chk("bp_stall_wr", uart_wr, 1'b0);
      end
      uart_busy = 1'b0;
      #1;
      chk("bp_ready_back", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("bp_wr_22", uart_wr, 1'b1);
      chk("bp_data_22", uart_tx_data, 8'h22);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("bp_end_grant", grant, 2'b00);

      // Lock timeout: req0 goes silent without last while req1 waits
      req_valid = 2'b01;
      req_data  = 16'h0055;
      @(negedge clk_48mhz);
      chk("to_grant_r0", grant, 2'b01);
      @(negedge clk_48mhz);
      chk("to_data_55", uart_tx_data, 8'h55);
      req_valid = 2'b10;
      req_data  = 16'h6655;
      req_last  = 2'b10;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_48mhz);
         chk("to_hold_r0", grant, 2'b01);
      end
      @(negedge clk_48mhz);
      chk("to_arb_idle", grant, 2'b00);
      @(negedge clk_48mhz);
      chk("to_grant_r1", grant, 2'b10);
      chk("to_ready_r1", req_ready, 2'b10);
      @(negedge clk_48mhz);
      chk("to_data_66", uart_tx_data, 8'h66);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("to_end_grant", grant, 2'b00);

      // No host: five bytes dropped, no strobes
      host_presence = 1'b0;
      req_valid     = 2'b01;
      req_data      = 16'h0077;
      @(negedge clk_48mhz);
      chk("nh_ready", req_ready, 2'b01);
      chk("nh_wr_1", uart_wr, 1'b0);
      for (int i = 2; i <= 10; i++) begin
         @(negedge clk_48mhz);
         chk("nh_wr", uart_wr, 1'b0);
         if (i == 2) chk("nh_drop_1", drop_count, 16'd1);
         if (i == 9) req_last = 2'b01;
      end
      chk("nh_drop_5", drop_count, 16'd5);
      req_valid = 2'b00;
      req_last  = 2'b00;
      @(negedge clk_48mhz);
      chk("nh_end_grant", grant, 2'b00);
      chk("nh_end_drop", drop_count, 16'd5);

      // Saturation from a preload of 0xFFFE with three more drops
      force dut.r_drop_count = 16'hFFFE;
      #1;
      release dut.r_drop_count;
      req_valid = 2'b01;
      req_data  = 16'h0088;
      @(negedge clk_48mhz);
      chk("sat_ready", req_ready, 2'b01);
      @(negedge clk_48mhz);
      chk("sat_drop_1", drop_count, 16'hFFFF);
      @(negedge clk_48mhz);
      @(negedge clk_48mhz);
      chk("sat_drop_2", drop_count, 16'hFFFF);
      @(negedge clk_48mhz);
      req_last = 2'b01;
      @(negedge clk_48mhz);
      chk("sat_drop_3", drop_count, 16'hFFFF);
      chk("sat_wr", uart_wr, 1'b0);
      req_valid     = 2'b00;
      req_last      = 2'b00;
      host_presence = 1'b1;
      @(negedge clk_48mhz);
      chk("sat_end_grant", grant, 2'b00);

      // Reset asserted while uart_wr is high
      req_valid = 2'b01;
      req_data  = 16'h0099;
      @(negedge clk_48mhz);
      chk("rm_grant", grant, 2'b01);
      @(negedge clk_48mhz);
      chk("rm_wr", uart_wr, 1'b1);
      chk("rm_data", uart_tx_data, 8'h99);
      #2;
      resetq = 1'b0;
      #1;
      chk("rm_async_grant", grant, 2'b00);
      chk("rm_async_ready", req_ready, 2'b00);
      chk("rm_async_wr", uart_wr, 1'b0);
      chk("rm_async_data", uart_tx_data, 8'h00);
      chk("rm_async_drop", drop_count, 16'h0000);
      req_valid = 2'b11;
      @(negedge clk_48mhz);
      chk("rm_held_grant", grant, 2'b00);
      resetq = 1'b1;
      @(negedge clk_48mhz);
      chk("rm_first_grant", grant, 2'b01);
      chk("rm_first_ready", req_ready, 2'b01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
